// File: rtl/ss_shift_sequencer.sv
// ss_shift_sequencer
//
// Drives an external serial-in/serial-out shift register of DEPTH stages.
// A start request latches a WIDTH-bit word, a direction bit and a fill bit.
// The word is then streamed LSB first into the register, followed by fill
// bits until every data bit has reached the far end. The bits that come out
// on sr_out are reassembled into data_out, and match reports whether the
// received word equals the word that was sent.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - transfer request, accepted only while idle
//   dir      - direction for the transfer, presented on sr_dir
//   fill     - bit value shifted in after the data bits
//   hold     - stall request while shifting
//   data_in  - word to send
//   sr_out   - serial output of the attached shift register
//   sr_in    - serial data to the shift register (registered)
//   sr_en    - shift enable to the shift register (registered)
//   sr_dir   - direction select to the shift register (registered)
//   busy     - transfer in progress
//   done     - one-cycle pulse, data_out/match updated
//   data_out - reassembled received word
//   match    - data_out equals the sent word
module ss_shift_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             fill,
  input  logic             hold,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr_out,
  output logic             sr_in,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             match
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH + DEPTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] word, word_next;
  logic [WIDTH-1:0] rx, rx_next, rx_capt;
  logic [WIDTH-1:0] data_out_next;
  logic             fill_l, fill_next;
  logic             sr_in_next, sr_en_next, sr_dir_next, match_next;
  logic             capture;

  // Bit to present for step k: data bits LSB first, then the fill value.
  function automatic logic bit_at(input logic [WIDTH-1:0] w,
                                  input logic f,
                                  input logic [CNT_W-1:0] k);
    logic b;
    b = f;
    for (int i = 0; i < WIDTH; i++)
      if (k == CNT_W'(i)) b = w[i];
    return b;
  endfunction

  // cnt is the step currently presented on sr_in (or pending while stalled).
  // During an enabled cycle for step k, k bits have already been accepted,
  // so the register's last stage holds bit k-DEPTH of the stream.
  always_comb begin
    capture = (state == SHIFT) && sr_en && (cnt >= CNT_W'(DEPTH));
    rx_capt = rx;
    for (int i = 0; i < WIDTH; i++)
      if (capture && cnt == CNT_W'(i + DEPTH)) rx_capt[i] = sr_out;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      word     <= '0;
      fill_l   <= 1'b0;
      rx       <= '0;
      sr_in    <= 1'b0;
      sr_en    <= 1'b0;
      sr_dir   <= 1'b0;
      data_out <= '0;
      match    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      word     <= word_next;
      fill_l   <= fill_next;
      rx       <= rx_next;
      sr_in    <= sr_in_next;
      sr_en    <= sr_en_next;
      sr_dir   <= sr_dir_next;
      data_out <= data_out_next;
      match    <= match_next;
    end
  end

  // Next-state logic. Step 0 is presented straight from the acceptance edge,
  // so hold decides, at each edge, whether the following cycle shifts.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    word_next     = word;
    fill_next     = fill_l;
    rx_next       = rx_capt;
    sr_in_next    = 1'b0;
    sr_en_next    = 1'b0;
    sr_dir_next   = sr_dir;
    data_out_next = data_out;
    match_next    = match;
    case (state)
      IDLE: begin
        sr_dir_next = 1'b0;
        if (start) begin
          word_next   = data_in;
          fill_next   = fill;
          cnt_next    = '0;
          rx_next     = '0;
          sr_en_next  = 1'b1;
          sr_in_next  = data_in[0];
          sr_dir_next = dir;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (sr_en && cnt == LAST) begin
          // Final bit is captured on this edge; publish the word directly.
          state_next    = DONE;
          data_out_next = rx_capt;
          match_next    = (rx_capt == word);
        end else begin
          if (sr_en) cnt_next = cnt + 1'b1;
          if (!hold) begin
            sr_en_next = 1'b1;
            sr_in_next = bit_at(word, fill_l, cnt_next);
          end
        end
      end
      DONE: begin
        state_next  = IDLE;
        sr_dir_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule
